// File: rtl/serial_sorter_if.sv
// Word-stream interface of the serial sorter: input frame, sorted output frame and status.
interface serial_sorter_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic [WIDTH-1:0] data_serial_i;
  logic             data_valid_i;
  logic             data_last_i;
  logic             descending_i;
  logic             data_ready_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] data_serial_o;
  logic             data_valid_o;
  logic             data_last_o;
  logic             busy_o;

  // Sorter side
  modport slave (
    input  data_serial_i, data_valid_i, data_last_i, descending_i, out_ready_i,
    output data_ready_o, data_serial_o, data_valid_o, data_last_o, busy_o
  );

  // Producer/consumer side
  modport master (
    output data_serial_i, data_valid_i, data_last_i, descending_i, out_ready_i,
    input  data_ready_o, data_serial_o, data_valid_o, data_last_o, busy_o
  );
endinterface

// File: rtl/serial_sorter.sv
// Frame sorter: loads up to DEPTH words, sorts them by odd-even transposition
// in DEPTH cycles, then streams the N loaded words back out in order.
module serial_sorter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 10,
  parameter bit          SIGNED = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_sorter_if.slave bus
);

  localparam int unsigned      CW        = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]    DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]    LAST_PASS = CW'(DEPTH - 1);
  localparam logic [WIDTH-1:0] MAX_VAL   = SIGNED ? {1'b0, {(WIDTH-1){1'b1}}} : {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_VAL   = SIGNED ? {1'b1, {(WIDTH-1){1'b0}}} : {WIDTH{1'b0}};

  typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] slot_q [DEPTH];
  logic [WIDTH-1:0] slot_n [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [CW-1:0]    k_q, k_n;
  logic             desc_q, desc_n;
  logic             ready_q, ready_n;
  logic             valid_q, valid_n;
  logic             last_q, last_n;
  logic             busy_q, busy_n;
  logic [WIDTH-1:0] data_q, data_n;
  logic             order_c;
  logic [WIDTH-1:0] cur_word_c, nxt_word_c;

  // True when the lower slot must move above the upper slot (equal words stay put)
  function automatic logic out_of_order(input logic [WIDTH-1:0] lo,
                                        input logic [WIDTH-1:0] hi,
                                        input logic             desc);
    logic gt, lt;
    if (SIGNED) begin
      gt = $signed(lo) > $signed(hi);
      lt = $signed(lo) < $signed(hi);
    end else begin
      gt = lo > hi;
      lt = lo < hi;
    end
    return desc ? lt : gt;
  endfunction

  // Read mux for the current and following output slot
  always_comb begin
    cur_word_c = '0;
    nxt_word_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (CW'(i) == k_q)          cur_word_c = slot_q[i];
      if (CW'(i) == k_q + CW'(1)) nxt_word_c = slot_q[i];
    end
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_n = state_q;
    slot_n  = slot_q;
    cnt_n   = cnt_q;
    k_n     = k_q;
    desc_n  = desc_q;
    data_n  = data_q;
    valid_n = valid_q;
    last_n  = last_q;
    order_c = desc_q;

    unique case (state_q)
      LOAD: begin
        if (bus.data_valid_i && ready_q) begin
          if (cnt_q == '0) begin
            order_c = bus.descending_i;
            desc_n  = bus.descending_i;
          end
          for (int i = 0; i < int'(DEPTH); i++) begin
            if (CW'(i) == cnt_q) slot_n[i] = bus.data_serial_i;
          end
          cnt_n = cnt_q + CW'(1);
          if (bus.data_last_i || cnt_n == DEPTH_CNT) begin
            // Pad unused slots with a value that sorts to the tail
            for (int i = 0; i < int'(DEPTH); i++) begin
              if (CW'(i) >= cnt_n) slot_n[i] = order_c ? MIN_VAL : MAX_VAL;
            end
            state_n = SORT;
            k_n     = '0;
          end
        end
      end
      SORT: begin
        // Even passes pair (0,1),(2,3)..; odd passes pair (1,2),(3,4)..
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
          if (((i % 2) == 1) == k_q[0]) begin
            if (out_of_order(slot_q[i], slot_q[i+1], desc_q)) begin
              slot_n[i]   = slot_q[i+1];
              slot_n[i+1] = slot_q[i];
            end
          end
        end
        if (k_q == LAST_PASS) begin
          state_n = OUT;
          k_n     = '0;
        end else begin
          k_n = k_q + CW'(1);
        end
      end
      OUT: begin
        if (!valid_q) begin
          valid_n = 1'b1;
          data_n  = cur_word_c;
          last_n  = (k_q == cnt_q - CW'(1));
        end else if (bus.out_ready_i) begin
          if (last_q) begin
            state_n = LOAD;
            valid_n = 1'b0;
            last_n  = 1'b0;
            data_n  = '0;
            cnt_n   = '0;
            k_n     = '0;
            desc_n  = 1'b0;
          end else begin
            k_n    = k_q + CW'(1);
            data_n = nxt_word_c;
            last_n = (k_q + CW'(1) == cnt_q - CW'(1));
          end
        end
      end
      default: state_n = LOAD;
    endcase

    ready_n = (state_n == LOAD);
    busy_n  = (state_n != LOAD);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      slot_q  <= '{default: '0};
      cnt_q   <= '0;
      k_q     <= '0;
      desc_q  <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_n;
      slot_q  <= slot_n;
      cnt_q   <= cnt_n;
      k_q     <= k_n;
      desc_q  <= desc_n;
      ready_q <= ready_n;
      valid_q <= valid_n;
      last_q  <= last_n;
      busy_q  <= busy_n;
      data_q  <= data_n;
    end
  end

  assign bus.data_ready_o  = ready_q;
  assign bus.data_serial_o = data_q;
  assign bus.data_valid_o  = valid_q;
  assign bus.data_last_o   = last_q;
  assign bus.busy_o        = busy_q;

endmodule

// File: tb/tb_serial_sorter.sv
// Bench for serial_sorter: a signed and an unsigned instance share the same
// stimulus; a reference sort fills per-instance scoreboards checked on output.
module tb_serial_sorter;

  localparam int unsigned W = 32;
  localparam int unsigned D = 10;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  int           cyc = 0;
  int           n_assert = 0;
  int           n_fail = 0;
  int           last_in_edge = 0;
  logic         in_valid, in_last, in_desc, out_rdy;
  logic [W-1:0] in_data;
  exp_t         exp_s[$];
  exp_t         exp_u[$];
  logic [W-1:0] words[$];
  bit           prev_v[2];
  bit           hold_pend[2];
  bit           hold_l[2];
  bit           last_done[2];
  logic [W-1:0] hold_d[2];

  serial_sorter_if #(.WIDTH(W)) if_s ();
  serial_sorter_if #(.WIDTH(W)) if_u ();

  serial_sorter #(.WIDTH(W), .DEPTH(D), .SIGNED(1'b1)) u_dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_s)
  );

  serial_sorter #(.WIDTH(W), .DEPTH(D), .SIGNED(1'b0)) u_dut_u (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_u)
  );

  assign if_s.data_serial_i = in_data;
  assign if_s.data_valid_i  = in_valid;
  assign if_s.data_last_i   = in_last;
  assign if_s.descending_i  = in_desc;
  assign if_s.out_ready_i   = out_rdy;
  assign if_u.data_serial_i = in_data;
  assign if_u.data_valid_i  = in_valid;
  assign if_u.data_last_i   = in_last;
  assign if_u.descending_i  = in_desc;
  assign if_u.out_ready_i   = out_rdy;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit goes_before(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input bit desc, input bit sgn);
    if (sgn) return desc ? ($signed(a) > $signed(b)) : ($signed(a) < $signed(b));
    return desc ? (a > b) : (a < b);
  endfunction

  // Insertion-sort the current frame and queue the expected output words
  task automatic push_expected(input bit desc, input bit sgn);
    logic [W-1:0] s[$];
    exp_t         e;
    for (int i = 0; i < words.size(); i++) begin
      int p = 0;
      while (p < s.size() && !goes_before(words[i], s[p], desc, sgn)) p++;
      s.insert(p, words[i]);
    end
    for (int i = 0; i < s.size(); i++) begin
      e.data = s[i];
      e.last = (i == s.size() - 1);
      if (sgn) exp_s.push_back(e);
      else     exp_u.push_back(e);
    end
  endtask

  // Drive one frame; the order input is flipped after the first word to test its latch
  task automatic send_frame(input bit desc, input bit use_last);
    bit acc;
    push_expected(desc, 1'b1);
    push_expected(desc, 1'b0);
    for (int i = 0; i < words.size(); i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      in_last  = use_last && (i == words.size() - 1);
      in_desc  = (i == 0) ? desc : !desc;
      acc = 1'b0;
      for (int t = 0; t < 50 && !acc; t++) begin
        @(negedge clk);
        acc = if_s.data_ready_o;
        @(posedge clk);
        #1;
      end
      chk($sformatf("accept_word_%0d", i), W'(acc), W'(1));
    end
    last_in_edge = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("s_busy_in_sort",  W'(if_s.busy_o),       W'(1));
    chk("u_busy_in_sort",  W'(if_u.busy_o),       W'(1));
    chk("s_ready_in_sort", W'(if_s.data_ready_o), W'(0));
    chk("u_ready_in_sort", W'(if_u.data_ready_o), W'(0));
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 300 && (exp_s.size() != 0 || exp_u.size() != 0); t++) @(posedge clk);
    #1;
    chk("s_drained", W'(exp_s.size()), W'(0));
    chk("u_drained", W'(exp_u.size()), W'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_s_ready"}, W'(if_s.data_ready_o), W'(0));
    chk({tag, "_s_valid"}, W'(if_s.data_valid_o), W'(0));
    chk({tag, "_s_last"},  W'(if_s.data_last_o),  W'(0));
    chk({tag, "_s_busy"},  W'(if_s.busy_o),       W'(0));
    chk({tag, "_s_data"},  if_s.data_serial_o,    W'(0));
    chk({tag, "_u_ready"}, W'(if_u.data_ready_o), W'(0));
    chk({tag, "_u_valid"}, W'(if_u.data_valid_o), W'(0));
    chk({tag, "_u_last"},  W'(if_u.data_last_o),  W'(0));
    chk({tag, "_u_busy"},  W'(if_u.busy_o),       W'(0));
    chk({tag, "_u_data"},  if_u.data_serial_o,    W'(0));
  endtask

  // Per-instance output checks, evaluated at the falling edge
  task automatic mon(input int id, input logic v, input logic [W-1:0] d,
                     input logic l, input logic ro);
    exp_t  e;
    int    qs;
    string nm;
    nm = (id == 0) ? "s" : "u";
    qs = (id == 0) ? exp_s.size() : exp_u.size();
    if (hold_pend[id]) begin
      chk({nm, "_hold_valid"}, W'(v), W'(1));
      chk({nm, "_hold_data"},  d,     hold_d[id]);
      chk({nm, "_hold_last"},  W'(l), W'(hold_l[id]));
    end
    if (last_done[id]) chk({nm, "_ready_after_last"}, W'({ro, v}), W'(2'b10));
    if (v && !prev_v[id]) chk({nm, "_latency"}, W'(cyc - last_in_edge), W'(D + 1));
    if (v && out_rdy) begin
      chk({nm, "_expected_pending"}, W'(qs != 0), W'(1));
      if (qs != 0) begin
        e = (id == 0) ? exp_s.pop_front() : exp_u.pop_front();
        chk({nm, "_out_data"}, d,     e.data);
        chk({nm, "_out_last"}, W'(l), W'(e.last));
      end
      hold_pend[id] = 1'b0;
      last_done[id] = l;
    end else if (v) begin
      hold_pend[id] = 1'b1;
      hold_d[id]    = d;
      hold_l[id]    = l;
      last_done[id] = 1'b0;
    end else begin
      hold_pend[id] = 1'b0;
      last_done[id] = 1'b0;
    end
    prev_v[id] = v;
  endtask

  // Output monitor for both instances
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        prev_v[i]    = 1'b0;
        hold_pend[i] = 1'b0;
        last_done[i] = 1'b0;
      end
    end else begin
      mon(0, if_s.data_valid_o, if_s.data_serial_o, if_s.data_last_o, if_s.data_ready_o);
      mon(1, if_u.data_valid_o, if_u.data_serial_o, if_u.data_last_o, if_u.data_ready_o);
    end
  end

  // Directed sequence
  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_desc  = 1'b0;
    in_data  = '0;
    out_rdy  = 1'b1;
    #2;
    check_zero("por");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("s_ready_before_edge", W'(if_s.data_ready_o), W'(0));
    @(posedge clk);
    #1;
    chk("s_ready_after_edge", W'(if_s.data_ready_o), W'(1));
    chk("u_ready_after_edge", W'(if_u.data_ready_o), W'(1));

    // Full ascending signed frame
    words = '{W'(5), W'(-3), W'(9), W'(0), W'(-3), W'(7), W'(1), W'(2), W'(8), W'(-1)};
    send_frame(1'b0, 1'b1);
    wait_drain();

    // Short descending frame; inputs offered during SORT must be ignored
    words = '{W'(4), W'(10), W'(-2)};
    send_frame(1'b1, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    in_last  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_drain();

    // Unsigned vs signed ordering of all-ones
    words = '{32'hFFFF_FFFF, W'(1)};
    send_frame(1'b0, 1'b1);
    wait_drain();

    // Data equal to the ascending sentinel
    words = '{32'h7FFF_FFFF, W'(3)};
    send_frame(1'b0, 1'b1);
    wait_drain();

    // Data equal to the descending sentinel
    words = '{32'h8000_0000, W'(5), W'(0)};
    send_frame(1'b1, 1'b1);
    wait_drain();

    // Full frame closed by word count, with 5 cycles of backpressure mid-output
    words.delete();
    for (int i = 0; i < int'(D); i++) words.push_back(W'($urandom_range(0, 15)) - W'(8));
    send_frame(1'b0, 1'b0);
    for (int t = 0; t < 100 && exp_s.size() > 7; t++) @(negedge clk);
    @(posedge clk);
    #1;
    out_rdy = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    out_rdy = 1'b1;
    wait_drain();

    // Reset in the middle of SORT discards the frame
    words = '{W'(11), W'(-7), W'(3), W'(3), W'(0), W'(20)};
    send_frame(1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("rst_sort");
    exp_s.delete();
    exp_u.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("u_ready_before_edge_2", W'(if_u.data_ready_o), W'(0));
    @(posedge clk);
    #1;
    chk("s_ready_after_edge_2", W'(if_s.data_ready_o), W'(1));
    words = '{W'(9), W'(-9), W'(0), W'(9)};
    send_frame(1'b1, 1'b1);
    wait_drain();

    // Single-word frame
    words = '{W'(42)};
    send_frame(1'b0, 1'b1);
    wait_drain();

    // Random frames with duplicates and random order
    for (int f = 0; f < 4; f++) begin
      int n;
      n = int'($urandom_range(1, D));
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom_range(0, 1) != 0 ? W'($urandom()) : W'($urandom_range(0, 3)));
      send_frame(1'($urandom_range(0, 1)), 1'b1);
      wait_drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
